// File: rtl/sort_pkg.sv
// Shared types and constants for the Core-Sort front end.
// Holds the loader state encoding, the count-width helper and the padding word.
package sort_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    ISSUE = 2'd2
  } loader_state_t;

  // Padding is all-ones so that it sorts to the top slots; users slice the low SIZE_DATA bits.
  localparam int PAD_MAX_W = 64;
  localparam logic [PAD_MAX_W-1:0] PAD_ALL_ONES = {PAD_MAX_W{1'b1}};

  function automatic int count_width(input int num_data);
    return $clog2(num_data + 1);
  endfunction

endpackage

// File: rtl/sort_input_loader.sv
// Serial-to-parallel loader: collects NUM_DATA words over valid/ready, pads short
// frames with all-ones and issues the vector with a one-cycle strobe.
module sort_input_loader
  import sort_pkg::*;
#(
  parameter int SIZE_DATA = 8,
  parameter int NUM_DATA  = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [SIZE_DATA-1:0]                i_data,
  input  logic                                i_valid,
  input  logic                                i_last,
  output logic                                o_ready,
  output logic [SIZE_DATA*NUM_DATA-1:0]       o_data_vec,
  output logic                                o_vec_valid,
  output logic [count_width(NUM_DATA)-1:0]    o_count
);

  localparam int IDX_W = $clog2(NUM_DATA);
  localparam int CNT_W = count_width(NUM_DATA);
  localparam logic [SIZE_DATA-1:0] PAD_WORD = PAD_ALL_ONES[SIZE_DATA-1:0];
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DATA);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (NUM_DATA < 2 || (NUM_DATA & (NUM_DATA - 1)) != 0) begin : g_bad_num_data
    $error("sort_input_loader: NUM_DATA must be a power of two and at least 2");
  end
  if (SIZE_DATA < 1 || SIZE_DATA > PAD_MAX_W) begin : g_bad_size_data
    $error("sort_input_loader: SIZE_DATA out of range");
  end

  loader_state_t                          state_r, state_nxt_s;
  logic [IDX_W-1:0]                       idx_r, idx_nxt_s;
  logic [CNT_W-1:0]                       cnt_r, cnt_nxt_s;
  logic [NUM_DATA-1:0][SIZE_DATA-1:0]     stage_r, stage_nxt_s;
  logic                                   accept_s;

  // Next-state, staging writes and padding.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    stage_nxt_s = stage_r;
    accept_s    = o_ready && i_valid && (state_r == FILL);
    case (state_r)
      FILL: begin
        if (accept_s) begin
          stage_nxt_s[idx_r] = i_data;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s   = '0;
            state_nxt_s = ISSUE;
          end else if (i_last) begin
            idx_nxt_s   = idx_r + IDX_ONE;
            cnt_nxt_s   = CNT_W'(idx_r) + CNT_ONE;
            state_nxt_s = PAD;
          end else begin
            idx_nxt_s   = idx_r + IDX_ONE;
            state_nxt_s = FILL;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      PAD: begin
        for (int k = 0; k < NUM_DATA; k++) begin
          if (CNT_W'(k) >= cnt_r) begin
            stage_nxt_s[k] = PAD_WORD;
          end else begin
            stage_nxt_s[k] = stage_r[k];
          end
        end
        state_nxt_s = ISSUE;
      end
      ISSUE: begin
        idx_nxt_s   = '0;
        state_nxt_s = FILL;
      end
      default: begin
        idx_nxt_s   = '0;
        state_nxt_s = FILL;
      end
    endcase
  end

  // State, staging and registered outputs; o_data_vec only moves on entry to ISSUE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= FILL;
      idx_r       <= '0;
      cnt_r       <= '0;
      stage_r     <= '0;
      o_ready     <= 1'b0;
      o_vec_valid <= 1'b0;
      o_data_vec  <= '0;
      o_count     <= '0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      cnt_r       <= cnt_nxt_s;
      stage_r     <= stage_nxt_s;
      o_ready     <= (state_nxt_s == FILL);
      o_vec_valid <= (state_nxt_s == ISSUE);
      if (state_nxt_s == ISSUE) begin
        o_data_vec <= stage_nxt_s;
        o_count    <= (state_r == PAD) ? cnt_r : CNT_FULL;
      end
    end
  end

endmodule

// File: tb/tb_sort_input_loader.sv
// Directed self-checking bench for sort_input_loader with SIZE_DATA=8, NUM_DATA=4.
module tb_sort_input_loader;

  localparam int SIZE_DATA = 8;
  localparam int NUM_DATA  = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic [31:0] o_data_vec;
  logic        o_vec_valid;
  logic [2:0]  o_count;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int strobe_base;

  sort_input_loader #(.SIZE_DATA(SIZE_DATA), .NUM_DATA(NUM_DATA)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_data_vec  (o_data_vec),
    .o_vec_valid (o_vec_valid),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  // Count strobes mid-cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (o_vec_valid) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    i_valid = v;
    i_data  = d;
    i_last  = l;
  endtask

  logic [7:0] bp_data [8] = '{8'h11, 8'hEE, 8'h22, 8'hEE, 8'h33, 8'hEE, 8'h44, 8'hEE};
  logic       bp_vld  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    i_rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    // Reset state
    cyc(); cyc();
    check_eq("rst_ready", o_ready, 1'b0);
    check_eq("rst_vvalid", o_vec_valid, 1'b0);
    check_eq("rst_vec", o_data_vec, 32'h0);
    check_eq("rst_count", o_count, 3'd0);
    i_rst_n = 1'b1;
    #2;
    check_eq("rel_ready_before_edge", o_ready, 1'b0);
    cyc();
    check_eq("rel_ready", o_ready, 1'b1);

    // Full frame
    strobe_base = strobe_cnt;
    drive(1'b1, 8'h12, 1'b0); cyc();
    drive(1'b1, 8'h05, 1'b0); cyc();
    drive(1'b1, 8'hA0, 1'b0); cyc();
    drive(1'b1, 8'h33, 1'b1); cyc();
    drive(1'b0, 8'h00, 1'b0);
    check_eq("full_vvalid", o_vec_valid, 1'b1);
    check_eq("full_vec", o_data_vec, 32'h33A00512);
    check_eq("full_count", o_count, 3'd4);
    check_eq("full_ready_low", o_ready, 1'b0);
    cyc();
    check_eq("full_ready_back", o_ready, 1'b1);
    check_eq("full_vvalid_drop", o_vec_valid, 1'b0);
    check_eq("full_vec_hold", o_data_vec, 32'h33A00512);
    check_eq("full_strobes", strobe_cnt - strobe_base, 1);

    // Short frame padded with all-ones
    strobe_base = strobe_cnt;
    drive(1'b1, 8'h07, 1'b0); cyc();
    drive(1'b1, 8'h02, 1'b1); cyc();
    drive(1'b1, 8'h99, 1'b0);
    check_eq("short_pad_ready", o_ready, 1'b0);
    check_eq("short_pad_vvalid", o_vec_valid, 1'b0);
    check_eq("short_pad_vec_hold", o_data_vec, 32'h33A00512);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    check_eq("short_ready", o_ready, 1'b0);
    check_eq("short_vvalid", o_vec_valid, 1'b1);
    check_eq("short_vec", o_data_vec, 32'hFFFF0207);
    check_eq("short_count", o_count, 3'd2);
    cyc();
    check_eq("short_ready_back", o_ready, 1'b1);
    check_eq("short_strobes", strobe_cnt - strobe_base, 1);

    // Gapped valid: only valid-cycle words are captured
    strobe_base = strobe_cnt;
    for (int i = 0; i < 7; i++) begin
      drive(bp_vld[i], bp_data[i], 1'b0);
      cyc();
      if (i < 6) check_eq($sformatf("gap_ready_%0d", i), o_ready, 1'b1);
    end
    drive(bp_vld[7], bp_data[7], 1'b0);
    check_eq("gap_vvalid", o_vec_valid, 1'b1);
    check_eq("gap_vec", o_data_vec, 32'h44332211);
    check_eq("gap_count", o_count, 3'd4);
    cyc(); cyc();
    check_eq("gap_strobes", strobe_cnt - strobe_base, 1);

    // Back-to-back frames with valid held high
    strobe_base = strobe_cnt;
    drive(1'b1, 8'h01, 1'b0); cyc();
    drive(1'b1, 8'h02, 1'b0); cyc();
    drive(1'b1, 8'h03, 1'b0); cyc();
    drive(1'b1, 8'h04, 1'b0); cyc();
    drive(1'b1, 8'h05, 1'b0);
    check_eq("b2b_1_vvalid", o_vec_valid, 1'b1);
    check_eq("b2b_1_vec", o_data_vec, 32'h04030201);
    check_eq("b2b_issue_ready", o_ready, 1'b0);
    cyc();
    check_eq("b2b_gap_vvalid", o_vec_valid, 1'b0);
    check_eq("b2b_ready_back", o_ready, 1'b1);
    cyc();
    drive(1'b1, 8'h06, 1'b0); cyc();
    drive(1'b1, 8'h07, 1'b0); cyc();
    drive(1'b1, 8'h08, 1'b0);
    check_eq("b2b_mid_vvalid", o_vec_valid, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    check_eq("b2b_2_vvalid", o_vec_valid, 1'b1);
    check_eq("b2b_2_vec", o_data_vec, 32'h08070605);
    check_eq("b2b_2_count", o_count, 3'd4);
    cyc();
    check_eq("b2b_strobes", strobe_cnt - strobe_base, 2);

    // Single all-ones word with last: legal data, count disambiguates
    drive(1'b1, 8'hFF, 1'b1); cyc();
    drive(1'b0, 8'h00, 1'b0); cyc();
    check_eq("single_vvalid", o_vec_valid, 1'b1);
    check_eq("single_vec", o_data_vec, 32'hFFFFFFFF);
    check_eq("single_count", o_count, 3'd1);
    cyc();

    // Mid-frame reset discards the partial frame
    strobe_base = strobe_cnt;
    drive(1'b1, 8'h55, 1'b0); cyc();
    drive(1'b1, 8'h66, 1'b0); cyc();
    drive(1'b0, 8'h00, 1'b0);
    i_rst_n = 1'b0;
    #2;
    check_eq("mrst_vec", o_data_vec, 32'h0);
    check_eq("mrst_ready", o_ready, 1'b0);
    check_eq("mrst_count", o_count, 3'd0);
    cyc();
    i_rst_n = 1'b1;
    cyc(); cyc();
    check_eq("mrst_no_strobe", strobe_cnt - strobe_base, 0);
    drive(1'b1, 8'h9A, 1'b0); cyc();
    drive(1'b1, 8'hBC, 1'b0); cyc();
    drive(1'b1, 8'hDE, 1'b0); cyc();
    drive(1'b1, 8'hF0, 1'b0); cyc();
    drive(1'b0, 8'h00, 1'b0);
    check_eq("post_rst_vvalid", o_vec_valid, 1'b1);
    check_eq("post_rst_vec", o_data_vec, 32'hF0DEBC9A);
    check_eq("post_rst_count", o_count, 3'd4);
    cyc(); cyc();
    check_eq("post_rst_strobes", strobe_cnt - strobe_base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
